pellet_grid: RTL and testbench

Parametrised, writable pellet bitmap for the maze game: a ROWS×COLS one-bit-per-cell store with a render read port and a collision read/clear port. It reloads itself from a layout ROM, one row per cycle, after reset or on request. It keeps a running pellet count and flags level completion. It sits between the sprite/tile renderer (port A) and the player-movement logic (port B).

---
 rtl/pellet_pkg.sv | 25 ++
 rtl/pellet_layout.sv | 26 ++
 rtl/pellet_grid.sv | 111 +++++++++++
 tb/tb_pellet_grid.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pellet_pkg.sv
// Shared types and constants for the pellet bitmap and its layout ROM.
package pellet_pkg;

  localparam int DEF_COLS = 32;
  localparam int DEF_ROWS = 32;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Default maze rows, bit x = column x. The 28-wide pattern spans columns 2..29.
  localparam logic [63:0] ROW_EDGE = 64'h0000_0000_3FFC_3FFC; // top row, gap over the ghost pen
  localparam logic [63:0] ROW_FULL = 64'h0000_0000_3FFF_FFFC; // cross corridors
  localparam logic [63:0] ROW_RAIL = 64'h0000_0000_2004_2004; // vertical corridors at 2,13,18,29

  // Ceiling log2, used for coordinate and count widths.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/pellet_layout.sv
// Combinational layout ROM: row index -> one row of pellet bits.
module pellet_layout import pellet_pkg::*; #(
  parameter int COLS = DEF_COLS,
  parameter int YW   = 5
) (
  input  logic [YW-1:0]   i_row,
  output logic [COLS-1:0] o_row
);

  logic [63:0] w_pat;
  int          w_r;

  // Pick the row pattern; anything outside rows 2..27 is empty.
  always_comb begin
    w_r   = int'(i_row);
    w_pat = '0;
    if (w_r == 2)
      w_pat = ROW_EDGE;
    else if (w_r == 8 || w_r == 14 || w_r == 20 || w_r == 27)
      w_pat = ROW_FULL;
    else if (w_r >= 3 && w_r <= 26)
      w_pat = ROW_RAIL;
    o_row = w_pat[COLS-1:0];
  end

endmodule

// File: rtl/pellet_grid.sv
// Pellet bitmap: render read port A, collision read/clear port B,
// self-reload from the layout ROM, running pellet count.
module pellet_grid import pellet_pkg::*; #(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS,
  parameter int XW   = clog2(COLS),
  parameter int YW   = clog2(ROWS),
  parameter int CW   = clog2(ROWS*COLS+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          refill,
  input  logic [XW-1:0] xpos_a,
  input  logic [YW-1:0] ypos_a,
  output logic          out_a,
  input  logic [XW-1:0] xpos_b,
  input  logic [YW-1:0] ypos_b,
  input  logic          clear_b,
  output logic          out_b,
  output logic          eaten,
  output logic [CW-1:0] remaining,
  output logic          all_clear,
  output logic          busy
);

  state_e                     r_state;
  logic [YW-1:0]              r_row;
  logic [ROWS-1:0][COLS-1:0]  r_mem;
  logic                       r_out_a, r_out_b, r_eaten;
  logic [CW-1:0]              r_remaining;

  logic [COLS-1:0] w_layout_row;
  logic [CW-1:0]   w_row_pop;
  logic            w_in_a, w_in_b, w_cell_a, w_cell_b, w_eat, w_last_row;

  pellet_layout #(.COLS(COLS), .YW(YW)) u_layout (
    .i_row (r_row),
    .o_row (w_layout_row)
  );

  assign w_row_pop  = CW'($countones(w_layout_row));
  assign w_last_row = (r_row == YW'(ROWS-1));

  // Out-of-range coordinates read as 0, which also blocks clears to them.
  assign w_in_a   = (int'(xpos_a) < COLS) && (int'(ypos_a) < ROWS);
  assign w_in_b   = (int'(xpos_b) < COLS) && (int'(ypos_b) < ROWS);
  assign w_cell_a = w_in_a ? r_mem[ypos_a][xpos_a] : 1'b0;
  assign w_cell_b = w_in_b ? r_mem[ypos_b][xpos_b] : 1'b0;

  // A clear only counts in RUN, on a set cell, and loses to a refill.
  assign w_eat = (r_state == ST_RUN) && clear_b && w_cell_b && !refill;

  // Control FSM with registered read data, eat pulse and pellet count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_FILL;
      r_row       <= '0;
      r_out_a     <= 1'b0;
      r_out_b     <= 1'b0;
      r_eaten     <= 1'b0;
      r_remaining <= '0;
    end else if (refill) begin
      r_state     <= ST_FILL;
      r_row       <= '0;
      r_out_a     <= 1'b0;
      r_out_b     <= 1'b0;
      r_eaten     <= 1'b0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        ST_FILL: begin
          r_out_a     <= 1'b0;
          r_out_b     <= 1'b0;
          r_eaten     <= 1'b0;
          r_remaining <= r_remaining + w_row_pop;
          if (w_last_row) begin
            r_state <= ST_RUN;
            r_row   <= '0;
          end else begin
            r_row <= r_row + YW'(1);
          end
        end
        default: begin
          r_out_a <= w_cell_a;
          r_out_b <= w_cell_b;
          r_eaten <= w_eat;
          if (w_eat && r_remaining != '0)
            r_remaining <= r_remaining - CW'(1);
        end
      endcase
    end
  end

  // Bitmap storage: row loads during FILL, single-bit clears during RUN.
  always_ff @(posedge clk) begin
    if (!refill) begin
      if (r_state == ST_FILL)
        r_mem[r_row] <= w_layout_row;
      else if (w_eat)
        r_mem[ypos_b][xpos_b] <= 1'b0;
    end
  end

  assign out_a     = r_out_a;
  assign out_b     = r_out_b;
  assign eaten     = r_eaten;
  assign remaining = r_remaining;
  assign busy      = (r_state == ST_FILL);
  assign all_clear = (r_remaining == '0) && (r_state == ST_RUN);

endmodule

// File: tb/tb_pellet_grid.sv
// Self-checking bench for pellet_grid: vector table, random traffic against
// a cell-array model, and hand sequences for refill, drain and reset.
module tb_pellet_grid;

  localparam int COLS  = 32;
  localparam int ROWS  = 32;
  localparam int CW    = 11;
  localparam int TOTAL = 220;

  logic          clk = 1'b0;
  logic          reset, refill, clear_b;
  logic [4:0]    xpos_a, ypos_a, xpos_b, ypos_b;
  logic          out_a, out_b, eaten, all_clear, busy;
  logic [CW-1:0] remaining;

  always #5 clk = ~clk;

  pellet_grid #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk       (clk),
    .reset     (reset),
    .refill    (refill),
    .xpos_a    (xpos_a),
    .ypos_a    (ypos_a),
    .out_a     (out_a),
    .xpos_b    (xpos_b),
    .ypos_b    (ypos_b),
    .clear_b   (clear_b),
    .out_b     (out_b),
    .eaten     (eaten),
    .remaining (remaining),
    .all_clear (all_clear),
    .busy      (busy)
  );

  int errors = 0;
  int checks = 0;

  // Model: the maze described as corridors, one bit per cell.
  bit m[ROWS][COLS];
  int m_rem;

  typedef struct {
    int xa, ya, xb, yb;
    bit clr;
    bit ea, eb, ee;
    int erem;
  } vec_t;
  vec_t vt[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int xa, input int ya, input int xb, input int yb, input bit clr);
    xpos_a  = 5'(xa);
    ypos_a  = 5'(ya);
    xpos_b  = 5'(xb);
    ypos_b  = 5'(yb);
    clear_b = clr;
  endtask

  // Top row with a gap at 14..17, four cross corridors, four vertical corridors.
  function automatic void model_init();
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) m[y][x] = 1'b0;
    for (int x = 2; x <= 29; x++) begin
      if (x <= 13 || x >= 18) m[2][x] = 1'b1;
      m[8][x] = 1'b1; m[14][x] = 1'b1; m[20][x] = 1'b1; m[27][x] = 1'b1;
    end
    for (int y = 3; y <= 26; y++) begin
      m[y][2] = 1'b1; m[y][13] = 1'b1; m[y][18] = 1'b1; m[y][29] = 1'b1;
    end
    m_rem = 0;
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) m_rem += int'(m[y][x]);
  endfunction

  // Wait for the fill to finish; returns the number of cycles busy stayed high.
  task automatic wait_fill(output int n);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    bit ea, eb, ee;
    int xa, ya, xb, yb;
    bit clr;

    vt[0] = '{2, 2, 14, 2, 0, 1, 0, 0, 220};
    vt[1] = '{2, 2, 2, 2, 1, 1, 1, 1, 219};
    vt[2] = '{0, 0, 2, 2, 1, 0, 0, 0, 219};
    vt[3] = '{3, 2, 3, 2, 1, 1, 1, 1, 218};
    vt[4] = '{3, 2, 0, 0, 0, 0, 0, 0, 218};
    vt[5] = '{29, 27, 15, 14, 1, 1, 1, 1, 217};
    vt[6] = '{15, 14, 1, 1, 1, 0, 0, 0, 217};
    vt[7] = '{13, 5, 14, 5, 0, 1, 0, 0, 217};

    reset  = 1'b1;
    refill = 1'b0;
    drive(0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    repeat (3) tick();
    check("rst_out_a", out_a, 0);
    check("rst_out_b", out_b, 0);
    check("rst_eaten", eaten, 0);
    check("rst_remaining", remaining, 0);
    check("rst_busy", busy, 1);
    check("rst_all_clear", all_clear, 0);

    reset = 1'b1;
    wait_fill(n);
    check("boot_fill_cycles", n, ROWS);
    check("boot_remaining", remaining, TOTAL);
    check("boot_all_clear", all_clear, 0);
    model_init();
    check("model_total", m_rem, TOTAL);

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].xa, vt[i].ya, vt[i].xb, vt[i].yb, vt[i].clr);
      tick();
      check($sformatf("vec%0d_out_a", i), out_a, vt[i].ea);
      check($sformatf("vec%0d_out_b", i), out_b, vt[i].eb);
      check($sformatf("vec%0d_eaten", i), eaten, vt[i].ee);
      check($sformatf("vec%0d_remaining", i), remaining, vt[i].erem);
      if (vt[i].clr && m[vt[i].yb][vt[i].xb]) begin
        m[vt[i].yb][vt[i].xb] = 1'b0;
        m_rem--;
      end
    end
    drive(0, 0, 0, 0, 0);
    tick();
    check("post_vec_conflict_read", out_a, 0);
    drive(3, 2, 0, 0, 0);
    tick();
    check("conflict_cell_now_empty", out_a, 0);

    // Random reads and clears against the model.
    for (int i = 0; i < 300; i++) begin
      xa = int'($urandom_range(31)); ya = int'($urandom_range(31));
      xb = int'($urandom_range(31)); yb = int'($urandom_range(31));
      if ($urandom_range(3) == 0) begin xa = xb; ya = yb; end
      clr = ($urandom_range(1) == 1);
      ea = m[ya][xa];
      eb = m[yb][xb];
      ee = clr && eb;
      if (ee) begin m[yb][xb] = 1'b0; m_rem--; end
      drive(xa, ya, xb, yb, clr);
      tick();
      check("rnd_out_a", out_a, ea);
      check("rnd_out_b", out_b, eb);
      check("rnd_eaten", eaten, ee);
      check("rnd_remaining", remaining, m_rem);
      check("rnd_all_clear", all_clear, (m_rem == 0));
    end

    // Refill together with a clear: the clear is dropped.
    drive(2, 2, 2, 2, 1);
    refill = 1'b1;
    tick();
    refill = 1'b0;
    drive(2, 2, 0, 0, 0);
    check("refill_busy", busy, 1);
    check("refill_remaining", remaining, 0);
    check("refill_eaten", eaten, 0);
    check("refill_all_clear", all_clear, 0);
    repeat (10) begin
      tick();
      check("fill_out_a", out_a, 0);
      check("fill_busy", busy, 1);
    end
    // Restart at fill row 10; keep clearing (2,2) through the whole fill.
    refill = 1'b1;
    tick();
    refill = 1'b0;
    drive(2, 2, 2, 2, 1);
    n = 0;
    while (busy && n < 100) begin
      check("fill_eaten", eaten, 0);
      check("fill_out_b", out_b, 0);
      tick();
      n++;
    end
    drive(2, 2, 0, 0, 0);
    check("refill2_cycles", n, ROWS);
    check("refill2_remaining", remaining, TOTAL);
    tick();
    check("refill2_cell_2_2", out_a, 1);
    check("refill2_remaining_hold", remaining, TOTAL);
    model_init();

    // Drain every pellet.
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++)
        if (m[y][x]) begin
          drive(x, y, x, y, 1);
          tick();
          m[y][x] = 1'b0;
          m_rem--;
          check("drain_eaten", eaten, 1);
          check("drain_remaining", remaining, m_rem);
        end
    check("drain_all_clear", all_clear, 1);
    check("drain_remaining_zero", remaining, 0);
    drive(2, 2, 2, 2, 1);
    tick();
    check("drain_empty_eaten", eaten, 0);
    check("drain_empty_remaining", remaining, 0);
    check("drain_empty_all_clear", all_clear, 1);

    // Refill, partial drain, then reset mid-drain.
    drive(0, 0, 0, 0, 0);
    refill = 1'b1;
    tick();
    refill = 1'b0;
    wait_fill(n);
    check("refill3_cycles", n, ROWS);
    model_init();
    n = 0;
    for (int y = 0; y < ROWS && n < 50; y++)
      for (int x = 0; x < COLS && n < 50; x++)
        if (m[y][x]) begin
          drive(x, y, x, y, 1);
          tick();
          n++;
        end
    check("partial_remaining", remaining, TOTAL - 50);
    reset = 1'b0;
    #1;
    check("midreset_remaining", remaining, 0);
    check("midreset_busy", busy, 1);
    check("midreset_eaten", eaten, 0);
    check("midreset_all_clear", all_clear, 0);
    drive(0, 0, 0, 0, 0);
    tick();
    reset = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
